// File: rtl/pes_siso_pkg.sv
// Shared definitions for the pes_siso serial delay line.
package pes_siso_pkg;

    // Default and maximum chain lengths (latency in clock cycles).
    localparam int PES_SISO_DEFAULT_DEPTH = 4;
    localparam int PES_SISO_MIN_DEPTH     = 1;
    localparam int PES_SISO_MAX_DEPTH     = 64;

    // One bit of the serial stream; four-state so X on the input travels
    // down the chain unchanged.
    typedef logic serial_bit_t;

    // True when a requested chain length can be built.
    function automatic bit depth_is_legal(input int depth);
        return (depth >= PES_SISO_MIN_DEPTH) && (depth <= PES_SISO_MAX_DEPTH);
    endfunction

endpackage : pes_siso_pkg

// File: rtl/pes_siso_stage.sv
// One link of the delay chain: a D flip-flop with asynchronous
// active-low reset to a configurable value.
module pes_siso_stage
    import pes_siso_pkg::*;
#(
    parameter serial_bit_t RESET_VALUE = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  serial_bit_t d_i,
    output serial_bit_t q_o
);

    serial_bit_t q_q;

    // Capture the upstream bit on every rising edge; clear at once on reset.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignment keeps every stage sampling the old
        // value of its neighbour, so the whole chain shifts in lockstep.
        if (!reset) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule : pes_siso_stage

// File: rtl/pes_siso.sv
// Serial-in, serial-out shift register: a fixed DEPTH-cycle delay line.
// Shifts on every rising clock edge while out of reset; no enable, no stall.
module pes_siso
    import pes_siso_pkg::*;
#(
    parameter int          DEPTH       = PES_SISO_DEFAULT_DEPTH,
    parameter serial_bit_t RESET_VALUE = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  serial_bit_t serial_in,
    output serial_bit_t serial_out
);

    // Elaboration-time guard on the chain length.
    if (!depth_is_legal(DEPTH)) begin : g_bad_depth
        $error("pes_siso: DEPTH=%0d outside legal range %0d..%0d",
               DEPTH, PES_SISO_MIN_DEPTH, PES_SISO_MAX_DEPTH);
    end

    // Full stage vector; bit 0 is fed by serial_in, bit DEPTH-1 drives the output.
    logic [DEPTH-1:0] stages;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        serial_bit_t stage_d;

        if (k == 0) begin : g_head
            assign stage_d = serial_in;
        end else begin : g_link
            assign stage_d = stages[k-1];
        end

        pes_siso_stage #(
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .d_i   (stage_d),
            .q_o   (stages[k])
        );
    end

    // Registered output straight from the last flop; no path from serial_in.
    assign serial_out = stages[DEPTH-1];

endmodule : pes_siso

// File: tb/tb_pes_siso.sv
// Directed bench for pes_siso: a DEPTH=4/RESET_VALUE=0 instance and a
// DEPTH=1/RESET_VALUE=1 instance sharing one clock.
module tb_pes_siso;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset4 = 1'b0;
    logic in4    = 1'b1;
    logic out4;
    logic reset1 = 1'b0;
    logic in1    = 1'b0;
    logic out1;

    int vectors     = 0;
    int miscompares = 0;

    pes_siso #(.DEPTH(4), .RESET_VALUE(1'b0)) dut4 (
        .clk        (clk),
        .reset      (reset4),
        .serial_in  (in4),
        .serial_out (out4)
    );

    pes_siso #(.DEPTH(1), .RESET_VALUE(1'b1)) dut1 (
        .clk        (clk),
        .reset      (reset1),
        .serial_in  (in1),
        .serial_out (out1)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] pat1;
        logic [5:0] seq1;
        int j;

        // Both instances held in reset from time zero.
        tick();
        tick();
        check("rst4_out", {7'd0, out4}, 8'h00);
        check("rst4_stages", {4'd0, dut4.stages}, 8'h00);
        check("rst1_out", {7'd0, out1}, 8'h01);

        // Latency: single-cycle pulse after release.
        reset4 = 1'b1;
        in4    = 1'b1;
        #1;
        check("rel_out", {7'd0, out4}, 8'h00);
        tick();                                   // edge 1
        check("pulse_e1_stages", {4'd0, dut4.stages}, 8'h01);
        check("pulse_e1", {7'd0, out4}, 8'h00);
        in4 = 1'b0;
        tick();
        check("pulse_e2", {7'd0, out4}, 8'h00);
        tick();
        check("pulse_e3", {7'd0, out4}, 8'h00);
        tick();
        check("pulse_e4", {7'd0, out4}, 8'h01);
        tick();
        check("pulse_e5", {7'd0, out4}, 8'h00);
        tick();
        check("pulse_e6", {7'd0, out4}, 8'h00);
        tick();
        check("pulse_e7", {7'd0, out4}, 8'h00);

        // Alternating stream; chain is all zeros here.
        for (int i = 0; i < 16; i++) begin
            in4 = i[0];
            tick();
            j = i - 3;
            check($sformatf("alt_%0d", i), {7'd0, out4}, (i >= 3) ? {7'd0, j[0]} : 8'h00);
        end
        check("alt_stages", {4'd0, dut4.stages}, 8'h05);

        // Fill with ones, then assert reset between edges while serial_in=1.
        in4 = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("fill_stages", {4'd0, dut4.stages}, 8'h0f);
        check("fill_out", {7'd0, out4}, 8'h01);
        @(negedge clk);
        reset4 = 1'b0;
        #1;
        check("async_clr_out", {7'd0, out4}, 8'h00);
        check("async_clr_stages", {4'd0, dut4.stages}, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_%0d", i), {4'd0, dut4.stages}, 8'h00);
            check($sformatf("hold_out_%0d", i), {7'd0, out4}, 8'h00);
        end

        // Refill, then a half-cycle reset pulse mid-stream and drive zeros.
        reset4 = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("refill_stages", {4'd0, dut4.stages}, 8'h0f);
        #1;
        reset4 = 1'b0;
        in4    = 1'b0;
        #1;
        check("mid_rst_out", {7'd0, out4}, 8'h00);
        check("mid_rst_stages", {4'd0, dut4.stages}, 8'h00);
        #4;
        reset4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("post_rst_%0d", i), {7'd0, out4}, 8'h00);
        end

        // DEPTH=1, RESET_VALUE=1: one-cycle follower.
        check("d1_rst_out", {7'd0, out1}, 8'h01);
        reset1 = 1'b1;
        #1;
        check("d1_rel_out", {7'd0, out1}, 8'h01);
        seq1 = 6'b100110;
        for (int i = 0; i < 6; i++) begin
            in1 = seq1[i];
            tick();
            check($sformatf("d1_follow_%0d", i), {7'd0, out1}, {7'd0, seq1[i]});
        end
        check("d1_stages", {7'd0, dut1.stages}, 8'h01);
        in1 = 1'b0;
        tick();
        check("d1_zero", {7'd0, out1}, 8'h00);
        #2;
        reset1 = 1'b0;
        #1;
        check("d1_async_set", {7'd0, out1}, 8'h01);
        pat1 = 4'b0000;
        tick();
        check("d1_hold", {7'd0, out1}, {7'd0, ~pat1[0]});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_pes_siso
